// File: rtl/garota_rst_seq_if.sv
// Violation/reset-request bundle between the GAROTA monitor (master) and the
// reset sequencer (slave).
interface garota_rst_seq_if;
  logic [6:0]  viol;
  logic [15:0] pc;
  logic        cause_clr;
  logic        sys_rst;
  logic [6:0]  cause;
  logic        cause_vld;
  logic [7:0]  viol_cnt;

  modport master (
    output viol, pc, cause_clr,
    input  sys_rst, cause, cause_vld, viol_cnt
  );

  modport slave (
    input  viol, pc, cause_clr,
    output sys_rst, cause, cause_vld, viol_cnt
  );
endinterface

// File: rtl/garota_rst_seq.sv
// GAROTA reset sequencer: stretches any violation into a HOLD_CYCLES+1 reset.
// Optional violation log (cause/cause_vld/viol_cnt) enabled by GAROTA_VIOL_LOG_EN.
module garota_rst_seq #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter logic [15:0] TCB_BASE      = 16'hFAE0,
  parameter logic [15:0] TCB_SIZE      = 16'h03FC,
  parameter logic [7:0]  HOLD_CYCLES   = 8'd4
) (
  input logic             clk,
  input logic             reset_n,
  garota_rst_seq_if.slave bus
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state;
  logic [7:0] hcnt;
  logic       any_viol;

  assign any_viol = |bus.viol;

  // Combinational so the CPU is reset in the very cycle the violation appears.
  assign bus.sys_rst = any_viol || (state == HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      hcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (any_viol) begin
            state <= HOLD;
            hcnt  <= HOLD_CYCLES - 8'd1;
          end
        end
        HOLD: begin
          if (any_viol) begin
            hcnt <= HOLD_CYCLES - 8'd1;
          end else if (hcnt != 8'd0) begin
            hcnt <= hcnt - 8'd1;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          hcnt  <= '0;
        end
      endcase
    end
  end

`ifdef GAROTA_VIOL_LOG_EN
  logic [6:0]  cause_q;
  logic        cause_vld_q;
  logic [7:0]  cnt_q;
  logic        in_tcb;
  logic        clr_ok;
  logic [16:0] tcb_last;
  logic [15:0] handler_unused;

  assign handler_unused = RESET_HANDLER;

  // 17-bit end address so a region touching 16'hFFFF cannot wrap.
  assign tcb_last = {1'b0, TCB_BASE} + {1'b0, TCB_SIZE};
  assign in_tcb   = (bus.pc >= TCB_BASE) && ({1'b0, bus.pc} <= tcb_last);
  assign clr_ok   = bus.cause_clr && (state == RUN) && !any_viol && in_tcb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q     <= '0;
      cause_vld_q <= 1'b0;
      cnt_q       <= '0;
    end else if ((state == RUN) && any_viol) begin
      if (!cause_vld_q) begin
        cause_q     <= bus.viol;
        cause_vld_q <= 1'b1;
      end
      if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else if (clr_ok) begin
      cause_q     <= '0;
      cause_vld_q <= 1'b0;
      cnt_q       <= '0;
    end
  end

  assign bus.cause     = cause_q;
  assign bus.cause_vld = cause_vld_q;
  assign bus.viol_cnt  = cnt_q;
`else
  logic        log_unused;
  logic [15:0] handler_unused;

  assign handler_unused = RESET_HANDLER ^ TCB_BASE ^ TCB_SIZE;
  assign log_unused     = bus.cause_clr ^ (^bus.pc);

  assign bus.cause     = '0;
  assign bus.cause_vld = 1'b0;
  assign bus.viol_cnt  = '0;
`endif

endmodule

// File: doc/garota_rst_seq.md
GAROTA_RST_SEQ -- requirements
Module: garota_rst_seq

Interface
REQ-001 SHALL have parameter RESET_HANDLER, default 16'h0000, meaning the PC value of the reset handler entry.
REQ-002 SHALL have parameter TCB_BASE, default 16'hFAE0, meaning the TCB region start address.
REQ-003 SHALL have parameter TCB_SIZE, default 16'h03FC, meaning the TCB region extent; the region is inclusive [TCB_BASE, TCB_BASE+TCB_SIZE].
REQ-004 SHALL have parameter HOLD_CYCLES, default 8'd4, meaning the number of cycles the registered reset is held; legal range 1..255.
REQ-005 SHALL have port clk input 1: the single system clock; all state is on rising edge.
REQ-006 SHALL have port reset_n input 1: asynchronous, active-low reset.
REQ-007 SHALL have port viol input 7: violation lines, bit0 pmem write, bit1..3 IRQ-config writes (UART, timer, GPIO), bit4 TCB atomicity, bit5 TCB IRQ, bit6 GIE disable.
REQ-008 SHALL have port pc input 16: current CPU program counter.
REQ-009 SHALL have port cause_clr input 1: request to clear the violation log.
REQ-010 SHALL have port sys_rst output 1: reset request to the CPU.
REQ-011 SHALL have port cause output 7: the violation bitmask captured at the first logged violation.
REQ-012 SHALL have port cause_vld output 1: cause holds a valid capture.
REQ-013 SHALL have port viol_cnt output 8: saturating count of violation events.

Function
REQ-014 SHALL implement FSM states RUN and HOLD, plus an 8-bit hold counter hcnt.
REQ-015 sys_rst SHALL equal (|viol) OR (state==HOLD), combinationally, so reset asserts in the same cycle as a violation.
REQ-016 In RUN with |viol=1, the FSM SHALL go to HOLD, load hcnt=HOLD_CYCLES-1, and increment viol_cnt by 1 (saturating at 8'hFF).
REQ-017 In HOLD with |viol=1, the FSM SHALL reload hcnt=HOLD_CYCLES-1 (extend the hold) and SHALL NOT increment viol_cnt.
REQ-018 In HOLD with |viol=0, hcnt SHALL decrement when nonzero; with hcnt==0 the FSM SHALL go to RUN on the next edge.
REQ-019 A single-cycle violation SHALL therefore yield sys_rst high for exactly HOLD_CYCLES+1 cycles: the violation cycle plus HOLD_CYCLES cycles in HOLD.
REQ-020 On the RUN->HOLD transition with cause_vld=0, cause SHALL capture viol and cause_vld SHALL set; if cause_vld=1, cause SHALL be unchanged.
REQ-021 cause_clr SHALL be honoured only when state==RUN, |viol==0, and pc lies inside the TCB region; it then clears cause, cause_vld and viol_cnt on the next edge.
REQ-022 A cause_clr not meeting REQ-021 SHALL be ignored with no side effect; when a violation and a clear coincide, the violation wins.
REQ-023 The FSM SHALL return to RUN only via hcnt expiry; pc==RESET_HANDLER SHALL NOT shorten the hold.

Reset
REQ-024 While reset_n=0, the block SHALL hold state=RUN, hcnt=0, cause=0, cause_vld=0, viol_cnt=0.
REQ-025 While reset_n=0, sys_rst SHALL equal |viol.
REQ-026 Deassertion of reset_n mid-HOLD SHALL resume in RUN with the log cleared.

Configuration
REQ-027 With macro GAROTA_VIOL_LOG_EN defined, cause, cause_vld and viol_cnt SHALL behave per REQ-016 to REQ-022.
REQ-028 Without GAROTA_VIOL_LOG_EN, cause, cause_vld and viol_cnt SHALL be tied to 0, cause_clr SHALL be ignored, and sys_rst/FSM timing SHALL be unchanged.

Verification
REQ-029 Scenario: viol=7'h01 for 1 cycle, HOLD_CYCLES=4 -> sys_rst high 5 cycles, cause=7'h01, cause_vld=1, viol_cnt=1.
REQ-030 Scenario: viol=7'h10, then viol=7'h40 two cycles later during HOLD -> hold extended to 4 cycles after the second violation, cause stays 7'h10, viol_cnt=1.
REQ-031 Scenario: two separate violations with RUN between them -> viol_cnt=2 and cause equals the first mask.
REQ-032 Scenario: cause_clr with pc=16'hFB00 in RUN -> log cleared; with pc=16'hE010 -> no change; with pc=16'hFB00 and viol=7'h02 -> log kept and viol_cnt incremented.
REQ-033 Scenario: 256 violation events -> viol_cnt saturates at 8'hFF.
REQ-034 Scenario: reset_n pulsed low mid-HOLD -> all outputs 0 (viol=0); build without GAROTA_VIOL_LOG_EN -> cause/viol_cnt stay 0 throughout.
